// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the half-period of a slow square wave in clk_in
//   cycles and recovers the divide-by target (P-1) that generated it.
// Latency: outputs register two clk_in edges after the input change is
//   captured by the first synchronizer flop. There is no backpressure;
//   valid is a single-cycle pulse per measured half-period.
// Ports:
//   clk_in, reset (sync, active-high), signal_in (async square wave)
//   level_out  : synchronized input level
//   period_out : last half-period P; target_out : P-1; phase_out : level of
//                the measured half-period
//   valid      : pulse on each measurement; stable : last MATCH_COUNT equal
//   timeout    : no input edge for TIMEOUT cycles
module clk_period_meter #(
  parameter int BIT_WIDTH   = 32,
  parameter int TIMEOUT     = 1000,
  parameter int MATCH_COUNT = 4
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 signal_in,
  output logic                 level_out,
  output logic [BIT_WIDTH-1:0] period_out,
  output logic [BIT_WIDTH-1:0] target_out,
  output logic                 phase_out,
  output logic                 valid,
  output logic                 stable,
  output logic                 timeout
);

  localparam int MW = $clog2(MATCH_COUNT);
  localparam logic [BIT_WIDTH-1:0] TMO_VAL   = BIT_WIDTH'(TIMEOUT);
  localparam logic [BIT_WIDTH-1:0] CNT_ONE   = BIT_WIDTH'(1);
  localparam logic [MW-1:0]        MATCH_MAX = MW'(MATCH_COUNT - 1);
  localparam logic [MW-1:0]        MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TIMEOUT = 2'd2
  } state_e;

  logic                 sync1_q, sync2_q, sync3_q;
  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MW-1:0]        match_q, match_d;
  logic                 first_q, first_d;
  logic [BIT_WIDTH-1:0] period_q, period_d;
  logic [BIT_WIDTH-1:0] target_q, target_d;
  logic                 phase_q, phase_d;
  logic                 valid_q, valid_d;
  logic                 stable_q, stable_d;
  logic                 timeout_q, timeout_d;
  logic                 edge_det;

  assign edge_det = sync2_q ^ sync3_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      match_q   <= '0;
      first_q   <= 1'b0;
      period_q  <= '0;
      target_q  <= '0;
      phase_q   <= 1'b0;
      valid_q   <= 1'b0;
      stable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= signal_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      first_q   <= first_d;
      period_q  <= period_d;
      target_q  <= target_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    first_d   = first_q;
    period_d  = period_q;
    target_d  = target_q;
    phase_d   = phase_q;
    valid_d   = 1'b0;
    stable_d  = stable_q;
    timeout_d = timeout_q;

    // Counter freezes while lost so it can never run past TIMEOUT.
    if (edge_det) begin
      cnt_d = CNT_ONE;
    end else if (state_q != S_TIMEOUT) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        // First edge is only a reference point; no interval to report yet.
        if (edge_det) begin
          state_d = S_MEASURE;
          first_d = 1'b1;
        end
      end
      S_MEASURE: begin
        // An edge coinciding with cnt == TIMEOUT is a legal measurement.
        if (edge_det) begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          target_d = cnt_q - CNT_ONE;
          phase_d  = sync3_q;
          first_d  = 1'b0;
          if (!first_q && (cnt_q == period_q)) begin
            match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_ONE;
          end else begin
            match_d = '0;
          end
          stable_d = (match_d == MATCH_MAX);
        end else if (cnt_q == TMO_VAL) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
          stable_d  = 1'b0;
          match_d   = '0;
        end
      end
      S_TIMEOUT: begin
        // The interval that ended here is unbounded, so it only re-arms.
        if (edge_det) begin
          state_d   = S_MEASURE;
          timeout_d = 1'b0;
          first_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign level_out  = sync2_q;
  assign period_out = period_q;
  assign target_out = target_q;
  assign phase_out  = phase_q;
  assign valid      = valid_q;
  assign stable     = stable_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: scoreboard bench for clk_period_meter.
// Stimulus toggles signal_in on falling clock edges; each toggle that should
// produce a measurement pushes the expected result, which the monitor pops.
module tb_clk_period_meter;

  localparam int BW  = 32;
  localparam int TMO = 16;
  localparam int MC  = 4;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          signal_in;
  logic          level_out;
  logic [BW-1:0] period_out;
  logic [BW-1:0] target_out;
  logic          phase_out;
  logic          valid;
  logic          stable;
  logic          timeout;

  clk_period_meter #(
    .BIT_WIDTH  (BW),
    .TIMEOUT    (TMO),
    .MATCH_COUNT(MC)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .signal_in (signal_in),
    .level_out (level_out),
    .period_out(period_out),
    .target_out(target_out),
    .phase_out (phase_out),
    .valid     (valid),
    .stable    (stable),
    .timeout   (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    bit ph;
    bit st;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   last_tog   = 0;
  bit   armed      = 0;
  int   run        = 0;
  int   prev_p     = 0;
  int   exp_rises  = 0;
  int   dut_rises  = 0;
  logic tmo_prev   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest pending expectation.
  always @(negedge clk_in) begin
    if (timeout === 1'b1 && tmo_prev !== 1'b1) dut_rises++;
    tmo_prev <= timeout;
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("period", 64'(period_out), 64'(e.p));
        chk("target", 64'(target_out), 64'(e.p - 1));
        chk("phase", 64'(phase_out), 64'(e.ph));
        chk("stable", 64'(stable), 64'(e.st));
        chk("timeout_at_valid", 64'(timeout), 64'd0);
      end
    end
  end

  // Wait n cycles, then toggle; the model decides what that edge should report.
  task automatic toggle_after(input int n);
    int   gap;
    exp_t e;
    repeat (n) @(negedge clk_in);
    gap = cyc - last_tog;
    if (!armed || gap > TMO) begin
      if (armed) exp_rises++;
      armed = 1;
      run   = 0;
    end else begin
      if (run > 0 && gap == prev_p) run++;
      else run = 1;
      prev_p = gap;
      e.p  = gap;
      e.ph = signal_in;
      e.st = (run >= MC);
      q.push_back(e);
    end
    last_tog  = cyc;
    signal_in = ~signal_in;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, 64'(level_out), 64'd0);
    chk({tag, "_period"}, 64'(period_out), 64'd0);
    chk({tag, "_target"}, 64'(target_out), 64'd0);
    chk({tag, "_phase"}, 64'(phase_out), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_stable"}, 64'(stable), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    signal_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    reset    = 1'b0;
    last_tog = cyc;

    // Divider target 4: arm, then six measurements of 5.
    toggle_after(5);
    repeat (6) toggle_after(5);

    // Target change to 9 while locked.
    repeat (5) toggle_after(10);

    // Hold the input: timeout exactly TMO cycles after the last edge cycle.
    repeat (TMO + 2) @(negedge clk_in);
    chk("tmo_early", 64'(timeout), 64'd0);
    @(negedge clk_in);
    chk("tmo_set", 64'(timeout), 64'd1);
    chk("tmo_stable", 64'(stable), 64'd0);
    chk("tmo_period_hold", 64'(period_out), 64'd10);
    toggle_after(5);
    repeat (3) @(negedge clk_in);
    chk("tmo_clear", 64'(timeout), 64'd0);
    toggle_after(4);

    // Edges exactly TMO apart are measured; TMO+1 apart always time out.
    repeat (4) toggle_after(TMO);
    repeat (3) toggle_after(TMO + 1);
    repeat (3) @(negedge clk_in);
    chk("tmo_rises", 64'(dut_rises), 64'(exp_rises));

    // Toggle every cycle.
    toggle_after(1);
    repeat (6) toggle_after(1);

    // Mid-interval reset with the input high.
    if (signal_in == 1'b0) toggle_after(3);
    repeat (4) @(negedge clk_in);
    chk("pre_reset_drain", 64'(q.size()), 64'd0);
    reset = 1'b1;
    @(negedge clk_in);
    chk_all_zero("midreset");
    reset     = 1'b0;
    armed     = 1;
    run       = 0;
    last_tog  = cyc;
    tmo_prev  = 1'b0;
    repeat (3) toggle_after(6);

    repeat (5) @(negedge clk_in);
    chk("tmo_rises_end", 64'(dut_rises), 64'(exp_rises));
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
